// File: rtl/pwm_compare_pkg.sv
// Shared types for the PWM compare block: run/drain FSM state encoding.
package pwm_compare_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   // States in which the PWM waveform is driven from the compare result.
   function automatic logic is_active_state(input state_e s);
      return (s == S_RUN) || (s == S_DRAIN);
   endfunction

endpackage

// File: rtl/pwm_compare_count_boundary_det.sv
// Detects real count progress and period boundaries on an upstream count bus
// whose counter may stall; a stalled value never re-triggers a boundary.
module count_boundary_det #(
   parameter int unsigned            DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0]  COUNT_FROM = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] count,
   output logic                  advance,
   output logic                  boundary
);

   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic                  first_q, first_d;

   // Previous-count history; the first cycle after reset always counts as progress.
   always_comb begin
      count_d  = count;
      first_d  = 1'b0;
      advance  = first_q | (count != count_q);
      boundary = advance & (count == COUNT_FROM);
   end

   // History registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         first_q <= 1'b1;
      end else begin
         count_q <= count_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/pwm_compare.sv
// PWM generator driven by an external count bus. The compare value is
// double-buffered (shadow loaded by valid/ready, applied at a period boundary)
// and a run/drain FSM lets the waveform stop cleanly at the end of a period.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | stopped, output inactive, shadow applied immediately
//   S_ARM   | run requested, waiting for the next period boundary
//   S_RUN   | generating PWM
//   S_DRAIN | stop requested, finishing the current period
module pwm_compare
   import pwm_compare_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH    = 8,
   parameter logic [DATA_WIDTH-1:0] COUNT_FROM    = '0,
   parameter bit                    INVERT        = 1'b0,
   parameter logic [DATA_WIDTH-1:0] COMPARE_RESET = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] count,
   input  logic [DATA_WIDTH-1:0] cmp_data,
   input  logic                  cmp_valid,
   output logic                  cmp_ready,
   output logic                  pwm_out,
   output logic                  match,
   output logic                  period_start,
   output logic                  busy
);

   logic advance;
   logic boundary;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] active_q, active_d;
   logic                  pwm_q, pwm_d;
   logic                  match_q, match_d;
   logic                  period_start_q, period_start_d;
   logic                  busy_q, busy_d;

   logic                  accept;
   logic                  apply;
   logic [DATA_WIDTH-1:0] eff_cmp;

   count_boundary_det #(
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_FROM (COUNT_FROM)
   ) u_det (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .advance  (advance),
      .boundary (boundary)
   );

   // Compare buffering, FSM next state and next output values.
   always_comb begin
      accept   = cmp_valid & ~full_q;
      apply    = full_q & (boundary | (state_q == S_IDLE));
      // A pending word takes effect on the boundary cycle itself.
      eff_cmp  = (boundary & full_q) ? shadow_q : active_q;

      shadow_d = shadow_q;
      full_d   = full_q;
      active_d = active_q;
      // accept needs an empty shadow and apply a full one, so they never collide.
      if (accept) begin
         shadow_d = cmp_data;
         full_d   = 1'b1;
      end
      if (apply) begin
         active_d = shadow_q;
         full_d   = 1'b0;
      end

      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (en) state_d = S_ARM;
         S_ARM:   if (!en) state_d = S_IDLE;
                  else if (boundary) state_d = S_RUN;
         S_RUN:   if (!en) state_d = S_DRAIN;
         S_DRAIN: if (en) state_d = S_RUN;
                  else if (boundary) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Drive from the compare whenever the FSM is, or is entering, an active
      // state: this covers ARM->RUN on the boundary and keeps the DRAIN->IDLE
      // boundary cycle inactive so no stray pulse starts a new period.
      pwm_d          = is_active_state(state_d) ? ((count < eff_cmp) ^ INVERT) : INVERT;
      match_d        = advance & (count == eff_cmp) & (state_q != S_IDLE);
      period_start_d = boundary & ((state_q == S_RUN) | ((state_q == S_ARM) & en));
      busy_d         = (state_d != S_IDLE);
   end

   // State and output registers; reset discards any pending shadow word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         shadow_q       <= '0;
         full_q         <= 1'b0;
         active_q       <= COMPARE_RESET;
         pwm_q          <= INVERT;
         match_q        <= 1'b0;
         period_start_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         shadow_q       <= shadow_d;
         full_q         <= full_d;
         active_q       <= active_d;
         pwm_q          <= pwm_d;
         match_q        <= match_d;
         period_start_q <= period_start_d;
         busy_q         <= busy_d;
      end
   end

   assign cmp_ready    = ~full_q;
   assign pwm_out      = pwm_q;
   assign match        = match_q;
   assign period_start = period_start_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare: one normal-polarity and one inverted instance
// sharing clock, reset and count bus.
module tb_pwm_compare;

   logic       clk;
   logic       rst;
   logic [7:0] count;

   logic       en, cmp_valid;
   logic [7:0] cmp_data;
   logic       cmp_ready, pwm_out, match, period_start, busy;

   logic       en_i, cmp_valid_i;
   logic [7:0] cmp_data_i;
   logic       cmp_ready_i, pwm_out_i, match_i, period_start_i, busy_i;

   int n_cmp = 0;
   int n_err = 0;

   int n_hi, n_match, match_at, n_ps, n_rdy0, n_busy0, n_hi_i, hi_i_at;

   pwm_compare #(.DATA_WIDTH(8), .COUNT_FROM(8'd0), .INVERT(1'b0), .COMPARE_RESET(8'd0)) dut (
      .clk(clk), .rst(rst), .en(en), .count(count),
      .cmp_data(cmp_data), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
      .pwm_out(pwm_out), .match(match), .period_start(period_start), .busy(busy)
   );

   pwm_compare #(.DATA_WIDTH(8), .COUNT_FROM(8'd0), .INVERT(1'b1), .COMPARE_RESET(8'd0)) dut_inv (
      .clk(clk), .rst(rst), .en(en_i), .count(count),
      .cmp_data(cmp_data_i), .cmp_valid(cmp_valid_i), .cmp_ready(cmp_ready_i),
      .pwm_out(pwm_out_i), .match(match_i), .period_start(period_start_i), .busy(busy_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      n_hi = 0; n_match = 0; match_at = -1; n_ps = 0;
      n_rdy0 = 0; n_busy0 = 0; n_hi_i = 0; hi_i_at = -1;
   endtask

   // Present counts lo..hi, one per clock; outputs seen #1 after the edge
   // belong to the count presented for that edge.
   task automatic run_counts(input int lo, input int hi);
      for (int c = lo; c <= hi; c++) begin
         count = c[7:0];
         @(posedge clk);
         #1;
         if (pwm_out) n_hi++;
         if (match) begin n_match++; match_at = c; end
         if (period_start) n_ps++;
         if (!cmp_ready) n_rdy0++;
         if (!busy) n_busy0++;
         if (pwm_out_i) begin n_hi_i++; hi_i_at = c; end
      end
   endtask

   initial begin
      rst = 1'b1; count = 8'd0;
      en = 1'b0; cmp_valid = 1'b0; cmp_data = 8'd0;
      en_i = 1'b0; cmp_valid_i = 1'b0; cmp_data_i = 8'd0;
      clr_stats();

      // Reset values
      #2 rst = 1'b0;
      #2;
      check_eq("rst_pwm",       32'(pwm_out),      32'd0);
      check_eq("rst_match",     32'(match),        32'd0);
      check_eq("rst_pstart",    32'(period_start), 32'd0);
      check_eq("rst_ready",     32'(cmp_ready),    32'd1);
      check_eq("rst_busy",      32'(busy),         32'd0);
      check_eq("rst_pwm_inv",   32'(pwm_out_i),    32'd1);
      #8 rst = 1'b1;

      // Load 64 while IDLE
      cmp_data = 8'd64; cmp_valid = 1'b1;
      run_counts(200, 200);
      check_eq("load_ready_lo", 32'(cmp_ready), 32'd0);
      cmp_valid = 1'b0;
      run_counts(200, 200);
      check_eq("idle_apply_ready", 32'(cmp_ready), 32'd1);

      // Enable: ARM until count wraps to 0
      en = 1'b1;
      clr_stats();
      run_counts(201, 255);
      check_eq("arm_hi",    n_hi,    32'd0);
      check_eq("arm_match", n_match, 32'd0);
      check_eq("arm_ps",    n_ps,    32'd0);
      check_eq("arm_busy0", n_busy0, 32'd0);

      // Period 1 at duty 64
      clr_stats();
      run_counts(0, 255);
      check_eq("p1_hi",       n_hi,     32'd64);
      check_eq("p1_match",    n_match,  32'd1);
      check_eq("p1_match_at", match_at, 32'd64);
      check_eq("p1_ps",       n_ps,     32'd1);

      // Period 2: load 128 at count 10, duty unchanged until the boundary
      clr_stats();
      run_counts(0, 9);
      cmp_data = 8'd128; cmp_valid = 1'b1;
      run_counts(10, 10);
      cmp_valid = 1'b0;
      run_counts(11, 255);
      check_eq("p2_hi",    n_hi,   32'd64);
      check_eq("p2_rdy0",  n_rdy0, 32'd246);
      check_eq("p2_match", n_match, 32'd1);

      // Period 3 at duty 128
      clr_stats();
      run_counts(0, 0);
      check_eq("p3_first_pwm", 32'(pwm_out), 32'd1);
      run_counts(1, 255);
      check_eq("p3_hi",       n_hi,     32'd128);
      check_eq("p3_match_at", match_at, 32'd128);
      check_eq("p3_rdy0",     n_rdy0,   32'd0);
      check_eq("p3_ps",       n_ps,     32'd1);

      // Counter stalled at 0 for 5 cycles
      clr_stats();
      for (int k = 0; k < 5; k++) run_counts(0, 0);
      run_counts(1, 255);
      check_eq("stall_ps",    n_ps,    32'd1);
      check_eq("stall_match", n_match, 32'd1);
      check_eq("stall_hi",    n_hi,    32'd132);

      // Drop en at count 100: drain to end of period, then IDLE
      clr_stats();
      run_counts(0, 99);
      en = 1'b0;
      run_counts(100, 255);
      check_eq("drain_hi",    n_hi,    32'd128);
      check_eq("drain_busy0", n_busy0, 32'd0);
      check_eq("drain_match", n_match, 32'd1);
      clr_stats();
      run_counts(0, 0);
      check_eq("stop_busy", 32'(busy),    32'd0);
      check_eq("stop_pwm",  32'(pwm_out), 32'd0);
      run_counts(1, 255);
      check_eq("idle_hi",    n_hi,    32'd0);
      check_eq("idle_match", n_match, 32'd0);
      check_eq("idle_ps",    n_ps,    32'd0);

      // Restart, pend a shadow word, then reset mid-run at count 37
      en = 1'b1;
      run_counts(1, 255);
      run_counts(0, 29);
      cmp_data = 8'd50; cmp_valid = 1'b1;
      run_counts(30, 30);
      cmp_valid = 1'b0;
      run_counts(31, 36);
      check_eq("pre_rst_pwm",   32'(pwm_out),   32'd1);
      check_eq("pre_rst_ready", 32'(cmp_ready), 32'd0);
      en = 1'b0;
      count = 8'd37;
      #2 rst = 1'b0;
      #1;
      check_eq("mid_rst_pwm",   32'(pwm_out),   32'd0);
      check_eq("mid_rst_match", 32'(match),     32'd0);
      check_eq("mid_rst_ready", 32'(cmp_ready), 32'd1);
      check_eq("mid_rst_busy",  32'(busy),      32'd0);
      #2 rst = 1'b1;

      // Inverted instance: cmp=0 gives constant 1
      cmp_data_i = 8'd0; cmp_valid_i = 1'b1;
      run_counts(38, 38);
      cmp_valid_i = 1'b0;
      run_counts(39, 39);
      en_i = 1'b1;
      run_counts(40, 255);
      clr_stats();
      run_counts(0, 4);
      cmp_data_i = 8'd255; cmp_valid_i = 1'b1;
      run_counts(5, 5);
      cmp_valid_i = 1'b0;
      run_counts(6, 255);
      check_eq("inv0_hi", n_hi_i, 32'd256);

      // Inverted instance: cmp=255 gives 1 only at count 255
      clr_stats();
      run_counts(0, 255);
      check_eq("inv255_hi",    n_hi_i,  32'd1);
      check_eq("inv255_hi_at", hi_i_at, 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
